// File: rtl/gshare_btb_ras_predictor.sv
// -----------------------------------------------------------------------------
// gshare_btb_ras_predictor
//
// Front-end branch predictor with three parts:
//   - gshare PHT: 2^PHT_BITS saturating counters, CTR_BITS wide. Each counter
//     is indexed by pc[2 +: PHT_BITS] XOR the global history.
//   - BTB: 2^BTB_SET_BITS sets x BTB_WAYS ways. Each entry holds a valid bit,
//     a tag, a target and a kind. Allocation uses a round-robin pointer per set.
//   - RAS: optional return address stack, built only when the BP_RAS_EN macro
//     is defined. Without it, returns predict the BTB target and the snapshot
//     output is tied to 0.
//
// Ports:
//   clock_i, reset_n_i        clock (rising edge), asynchronous active-low reset
//   predict_valid_i/pc_i      fetch lookup; the prediction is combinational
//   predict_used_i            fetch consumed the prediction, so the speculative
//                             GHR/RAS update is committed
//   predict_taken_o/target_o  redirect request (target is 0 when not taken)
//   predict_ghr_o             history used for this lookup
//   predict_ras_snap_o        {count, ptr} before this lookup
//   train_*                   resolved control-flow instruction from execute
//   recover_i/ghr_i/ras_snap_i  mispredict recovery of GHR and RAS {count, ptr}
// -----------------------------------------------------------------------------
module gshare_btb_ras_predictor #(
   parameter int GH           = 8,
   parameter int PHT_BITS     = 10,
   parameter int CTR_BITS     = 2,
   parameter int BTB_SET_BITS = 6,
   parameter int BTB_WAYS     = 2,
   parameter int RAS_DEPTH    = 8,
   localparam int RAS_PTR_W   = $clog2(RAS_DEPTH),
   localparam int RAS_CNT_W   = $clog2(RAS_DEPTH + 1),
   localparam int RAS_SNAP_W  = RAS_PTR_W + RAS_CNT_W
) (
   input  logic                  clock_i,
   input  logic                  reset_n_i,
   input  logic                  predict_valid_i,
   input  logic [31:0]           predict_pc_i,
   input  logic                  predict_used_i,
   output logic                  predict_taken_o,
   output logic [31:0]           predict_target_o,
   output logic [GH-1:0]         predict_ghr_o,
   output logic [RAS_SNAP_W-1:0] predict_ras_snap_o,
   input  logic                  train_valid_i,
   input  logic [31:0]           train_pc_i,
   input  logic [1:0]            train_kind_i,
   input  logic                  train_taken_i,
   input  logic [31:0]           train_target_i,
   input  logic [GH-1:0]         train_ghr_i,
   input  logic                  recover_i,
   input  logic [GH-1:0]         recover_ghr_i,
   input  logic [RAS_SNAP_W-1:0] recover_ras_snap_i
);
   localparam int PHT_ENTRIES = 1 << PHT_BITS;
   localparam int BTB_SETS    = 1 << BTB_SET_BITS;
   localparam int TAG_W       = 30 - BTB_SET_BITS;
   localparam int WAY_W       = (BTB_WAYS > 1) ? $clog2(BTB_WAYS) : 1;
   localparam int HIT_CNT_W   = $clog2(BTB_WAYS + 1);
   localparam int HIST_W      = (GH < PHT_BITS) ? GH : PHT_BITS;
   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
   localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
   localparam logic [1:0] K_COND = 2'b00;
   localparam logic [1:0] K_CALL = 2'b10;
   localparam logic [1:0] K_RET  = 2'b11;

   // State
   logic [CTR_BITS-1:0] pht_q [PHT_ENTRIES];
   logic [BTB_WAYS-1:0] btb_valid_q [BTB_SETS];
   logic [TAG_W-1:0]    btb_tag_q [BTB_SETS][BTB_WAYS];
   logic [31:0]         btb_tgt_q [BTB_SETS][BTB_WAYS];
   logic [1:0]          btb_kind_q [BTB_SETS][BTB_WAYS];
   logic [WAY_W-1:0]    rr_q [BTB_SETS];
   logic [GH-1:0]       ghr_q;

   // Address decode for the lookup and training ports
   logic [BTB_SET_BITS-1:0] p_set, t_set;
   logic [TAG_W-1:0]        p_tag, t_tag;
   logic [PHT_BITS-1:0]     p_hist, t_hist, p_idx, t_idx;

   assign p_set = predict_pc_i[2 +: BTB_SET_BITS];
   assign t_set = train_pc_i[2 +: BTB_SET_BITS];
   assign p_tag = predict_pc_i[31 -: TAG_W];
   assign t_tag = train_pc_i[31 -: TAG_W];

   // History is zero-extended (or truncated) to the PHT index width
   always_comb begin
      p_hist = '0;
      t_hist = '0;
      p_hist[HIST_W-1:0] = ghr_q[HIST_W-1:0];
      t_hist[HIST_W-1:0] = train_ghr_i[HIST_W-1:0];
   end
   assign p_idx = predict_pc_i[2 +: PHT_BITS] ^ p_hist;
   assign t_idx = train_pc_i[2 +: PHT_BITS] ^ t_hist;

   // Tag match. The lookup counts matching ways because a hit must be
   // unambiguous. Training takes the lowest matching way.
   logic [HIT_CNT_W-1:0] p_hits;
   logic [WAY_W-1:0]     p_way, t_way;
   logic                 t_hit;
   always_comb begin
      p_hits = '0;
      p_way  = '0;
      t_hit  = 1'b0;
      t_way  = '0;
      for (int w = BTB_WAYS - 1; w >= 0; w--) begin
         if (btb_valid_q[p_set][w] && (btb_tag_q[p_set][w] == p_tag)) begin
            p_hits = p_hits + HIT_CNT_W'(1);
            p_way  = WAY_W'(w);
         end
         if (btb_valid_q[t_set][w] && (btb_tag_q[t_set][w] == t_tag)) begin
            t_hit = 1'b1;
            t_way = WAY_W'(w);
         end
      end
   end

   logic        p_hit, p_ctr_msb, p_taken, spec_upd, ras_nonempty;
   logic [1:0]  p_kind;
   logic [31:0] p_btb_tgt, p_target, ras_top;

   assign p_hit     = predict_valid_i && (p_hits == HIT_CNT_W'(1));
   assign p_kind    = btb_kind_q[p_set][p_way];
   assign p_btb_tgt = btb_tgt_q[p_set][p_way];
   assign p_ctr_msb = pht_q[p_idx][CTR_BITS-1];
   assign spec_upd  = p_hit && predict_used_i;

   always_comb begin
      p_taken  = 1'b0;
      p_target = '0;
      if (p_hit) begin
         case (p_kind)
            K_COND: begin
               p_taken  = p_ctr_msb;
               p_target = p_ctr_msb ? p_btb_tgt : '0;
            end
            K_RET: begin
               p_taken  = 1'b1;
               p_target = ras_nonempty ? ras_top : p_btb_tgt;
            end
            default: begin
               p_taken  = 1'b1;
               p_target = p_btb_tgt;
            end
         endcase
      end
   end

   assign predict_taken_o  = p_taken;
   assign predict_target_o = p_target;
   assign predict_ghr_o    = ghr_q;

   // Global history. Recovery wins over a same-cycle speculative shift.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         ghr_q <= '0;
      end else if (recover_i) begin
         ghr_q <= recover_ghr_i;
      end else if (spec_upd && (p_kind == K_COND)) begin
         ghr_q <= {ghr_q[GH-2:0], p_taken};
      end
   end

   // PHT training, saturating at both ends
   logic [CTR_BITS-1:0] t_ctr, t_ctr_d;
   assign t_ctr   = pht_q[t_idx];
   assign t_ctr_d = train_taken_i ? ((t_ctr == CTR_MAX) ? t_ctr : t_ctr + CTR_BITS'(1))
                                  : ((t_ctr == '0) ? t_ctr : t_ctr - CTR_BITS'(1));

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= CTR_INIT;
      end else if (train_valid_i && (train_kind_i == K_COND)) begin
         pht_q[t_idx] <= t_ctr_d;
      end
   end

   // BTB training: only taken outcomes write. A hit rewrites in place; a miss
   // replaces the round-robin victim.
   logic             btb_wr;
   logic [WAY_W-1:0] wr_way, rr_next;
   assign btb_wr  = train_valid_i && train_taken_i;
   assign wr_way  = t_hit ? t_way : rr_q[t_set];
   assign rr_next = (rr_q[t_set] == WAY_W'(BTB_WAYS - 1)) ? '0 : rr_q[t_set] + WAY_W'(1);

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int s = 0; s < BTB_SETS; s++) begin
            btb_valid_q[s] <= '0;
            rr_q[s]        <= '0;
         end
      end else if (btb_wr) begin
         btb_valid_q[t_set][wr_way] <= 1'b1;
         if (!t_hit) rr_q[t_set] <= rr_next;
      end
   end

   // Payload needs no reset: it is qualified by the valid bits
   always_ff @(posedge clock_i) begin
      if (btb_wr) begin
         btb_tag_q[t_set][wr_way]  <= t_tag;
         btb_tgt_q[t_set][wr_way]  <= train_target_i;
         btb_kind_q[t_set][wr_way] <= train_kind_i;
      end
   end

   logic unused_bits;
`ifdef BP_RAS_EN
   logic [31:0]          ras_stack_q [RAS_DEPTH];
   logic [RAS_PTR_W-1:0] ras_ptr_q, ras_ptr_d;
   logic [RAS_CNT_W-1:0] ras_cnt_q, ras_cnt_d;

   assign ras_top      = ras_stack_q[ras_ptr_q];
   assign ras_nonempty = (ras_cnt_q != '0);

   // The pointer wraps, so an overflowing call overwrites the oldest entry
   // while the count saturates at the depth.
   always_comb begin
      ras_ptr_d = ras_ptr_q;
      ras_cnt_d = ras_cnt_q;
      if (recover_i) begin
         {ras_cnt_d, ras_ptr_d} = recover_ras_snap_i;
      end else if (spec_upd && (p_kind == K_CALL)) begin
         ras_ptr_d = ras_ptr_q + RAS_PTR_W'(1);
         if (ras_cnt_q != RAS_CNT_W'(RAS_DEPTH)) ras_cnt_d = ras_cnt_q + RAS_CNT_W'(1);
      end else if (spec_upd && (p_kind == K_RET) && ras_nonempty) begin
         ras_ptr_d = ras_ptr_q - RAS_PTR_W'(1);
         ras_cnt_d = ras_cnt_q - RAS_CNT_W'(1);
      end
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         ras_ptr_q <= '0;
         ras_cnt_q <= '0;
      end else begin
         ras_ptr_q <= ras_ptr_d;
         ras_cnt_q <= ras_cnt_d;
      end
   end

   always_ff @(posedge clock_i) begin
      if (spec_upd && (p_kind == K_CALL) && !recover_i)
         ras_stack_q[ras_ptr_d] <= predict_pc_i + 32'd4;
   end

   assign predict_ras_snap_o = {ras_cnt_q, ras_ptr_q};
   assign unused_bits = ^{predict_pc_i[1:0], train_pc_i[1:0], train_ghr_i};
`else
   assign ras_top            = '0;
   assign ras_nonempty       = 1'b0;
   assign predict_ras_snap_o = '0;
   assign unused_bits = ^{predict_pc_i[1:0], train_pc_i[1:0], train_ghr_i, recover_ras_snap_i};
`endif

endmodule

// File: tb/tb_gshare_btb_ras_predictor.sv
`timescale 1ns/1ps
module tb_gshare_btb_ras_predictor;
   localparam int GH = 8;
   localparam int SNAP_W = 7;
`ifdef BP_RAS_EN
   localparam bit RAS_ON = 1'b1;
`else
   localparam bit RAS_ON = 1'b0;
`endif

   logic              clock_i = 1'b0;
   logic              reset_n_i = 1'b0;
   logic              predict_valid_i, predict_used_i;
   logic [31:0]       predict_pc_i;
   logic              predict_taken_o;
   logic [31:0]       predict_target_o;
   logic [GH-1:0]     predict_ghr_o;
   logic [SNAP_W-1:0] predict_ras_snap_o;
   logic              train_valid_i, train_taken_i;
   logic [31:0]       train_pc_i, train_target_i;
   logic [1:0]        train_kind_i;
   logic [GH-1:0]     train_ghr_i;
   logic              recover_i;
   logic [GH-1:0]     recover_ghr_i;
   logic [SNAP_W-1:0] recover_ras_snap_i;

   int passed = 0;
   int total  = 0;
   int txn    = 0;

   always #5 clock_i = ~clock_i;

   gshare_btb_ras_predictor dut (
      .clock_i(clock_i), .reset_n_i(reset_n_i),
      .predict_valid_i(predict_valid_i), .predict_pc_i(predict_pc_i),
      .predict_used_i(predict_used_i), .predict_taken_o(predict_taken_o),
      .predict_target_o(predict_target_o), .predict_ghr_o(predict_ghr_o),
      .predict_ras_snap_o(predict_ras_snap_o),
      .train_valid_i(train_valid_i), .train_pc_i(train_pc_i),
      .train_kind_i(train_kind_i), .train_taken_i(train_taken_i),
      .train_target_i(train_target_i), .train_ghr_i(train_ghr_i),
      .recover_i(recover_i), .recover_ghr_i(recover_ghr_i),
      .recover_ras_snap_i(recover_ras_snap_i)
   );

   // ---------------- reference model (default parameters) ----------------
   int        m_pht [1024];
   bit        m_v   [64][2];
   bit [31:0] m_tag [64][2];
   bit [31:0] m_tgt [64][2];
   bit [1:0]  m_kind[64][2];
   int        m_rr  [64];
   bit [7:0]  m_ghr;
   int        m_ptr, m_cnt;
   bit [31:0] m_stk [8];

   function automatic void model_reset();
      for (int i = 0; i < 1024; i++) m_pht[i] = 1;
      for (int s = 0; s < 64; s++) begin
         m_rr[s] = 0;
         for (int w = 0; w < 2; w++) m_v[s][w] = 1'b0;
      end
      m_ghr = 8'h00;
      m_ptr = 0;
      m_cnt = 0;
   endfunction

   function automatic void model_predict(input bit [31:0] pc, input bit v, output bit hit,
                                         output bit [1:0] kind, output bit tk, output bit [31:0] tg);
      int set = int'((pc >> 2) & 32'h3f);
      int n = 0;
      int way = 0;
      int idx;
      for (int w = 0; w < 2; w++)
         if (m_v[set][w] && m_tag[set][w] == (pc >> 8)) begin n++; way = w; end
      hit  = v && (n == 1);
      kind = m_kind[set][way];
      tk   = 1'b0;
      tg   = 32'h0;
      if (hit) begin
         if (kind == 2'd0) begin
            idx = int'((pc >> 2) & 32'h3ff) ^ int'(m_ghr);
            tk  = (m_pht[idx] >= 2);
            tg  = tk ? m_tgt[set][way] : 32'h0;
         end else if (kind == 2'd3) begin
            tk = 1'b1;
            tg = (RAS_ON && m_cnt > 0) ? m_stk[m_ptr] : m_tgt[set][way];
         end else begin
            tk = 1'b1;
            tg = m_tgt[set][way];
         end
      end
   endfunction

   function automatic bit [6:0] model_snap();
      return RAS_ON ? 7'((m_cnt << 3) | m_ptr) : 7'h0;
   endfunction

   // Applies one clock edge worth of effects using the current inputs.
   function automatic void model_commit();
      bit hit, tk, found;
      bit [1:0] kind;
      bit [31:0] tg;
      int set, idx, way;
      model_predict(predict_pc_i, predict_valid_i, hit, kind, tk, tg);
      if (train_valid_i) begin
         if (train_kind_i == 2'd0) begin
            idx = int'((train_pc_i >> 2) & 32'h3ff) ^ int'(train_ghr_i);
            if (train_taken_i) m_pht[idx] = (m_pht[idx] == 3) ? 3 : m_pht[idx] + 1;
            else               m_pht[idx] = (m_pht[idx] == 0) ? 0 : m_pht[idx] - 1;
         end
         if (train_taken_i) begin
            set = int'((train_pc_i >> 2) & 32'h3f);
            found = 1'b0;
            way = 0;
            for (int w = 0; w < 2; w++)
               if (!found && m_v[set][w] && m_tag[set][w] == (train_pc_i >> 8)) begin
                  found = 1'b1;
                  way = w;
               end
            if (!found) begin
               way = m_rr[set];
               m_rr[set] = (m_rr[set] + 1) % 2;
            end
            m_v[set][way]    = 1'b1;
            m_tag[set][way]  = train_pc_i >> 8;
            m_tgt[set][way]  = train_target_i;
            m_kind[set][way] = train_kind_i;
         end
      end
      if (recover_i) begin
         m_ghr = recover_ghr_i;
         m_cnt = int'(recover_ras_snap_i >> 3);
         m_ptr = int'(recover_ras_snap_i & 7'h7);
      end else if (hit && predict_used_i) begin
         if (kind == 2'd0) m_ghr = (m_ghr << 1) | 8'(tk);
         else if (kind == 2'd2) begin
            m_ptr = (m_ptr + 1) % 8;
            m_stk[m_ptr] = predict_pc_i + 32'd4;
            if (m_cnt < 8) m_cnt++;
         end else if (kind == 2'd3 && m_cnt > 0) begin
            m_ptr = (m_ptr + 7) % 8;
            m_cnt--;
         end
      end
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic clear_inputs();
      predict_valid_i = 0; predict_used_i = 0; predict_pc_i = 0;
      train_valid_i = 0; train_taken_i = 0; train_pc_i = 0; train_target_i = 0;
      train_kind_i = 0; train_ghr_i = 0;
      recover_i = 0; recover_ghr_i = 0; recover_ras_snap_i = 0;
   endtask

   // Called shortly after a falling edge; commits one rising edge.
   task automatic step(input string tag);
      $display("txn %0d %s: pv=%0b pc=%h used=%0b | tv=%0b tpc=%h kind=%0d tk=%0b tgt=%h | rec=%0b",
               txn, tag, predict_valid_i, predict_pc_i, predict_used_i, train_valid_i, train_pc_i,
               train_kind_i, train_taken_i, train_target_i, recover_i);
      txn++;
      model_commit();
      @(posedge clock_i);
      @(negedge clock_i);
      clear_inputs();
   endtask

   task automatic train(input bit [31:0] pc, input bit [1:0] kind, input bit tk, input bit [31:0] tgt);
      train_valid_i = 1; train_pc_i = pc; train_kind_i = kind; train_taken_i = tk;
      train_target_i = tgt; train_ghr_i = 8'h00;
   endtask

   function automatic bit [31:0] rand_pc();
      return 32'(($urandom_range(0, 7) << 8) | ($urandom_range(0, 3) << 2));
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_n_i = 0;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clock_i);
      @(negedge clock_i);
      predict_valid_i = 1; predict_pc_i = 32'h100;
      #1;
      total++; if (predict_taken_o !== 1'b0) $display("FAIL rst_taken got=%0b exp=0", predict_taken_o); else passed++;
      total++; if (predict_target_o !== 32'h0) $display("FAIL rst_target got=%h exp=0", predict_target_o); else passed++;
      total++; if (predict_ghr_o !== 8'h0) $display("FAIL rst_ghr got=%h exp=0", predict_ghr_o); else passed++;
      total++; if (predict_ras_snap_o !== 7'h0) $display("FAIL rst_snap got=%h exp=0", predict_ras_snap_o); else passed++;
      reset_n_i = 1;
      step("reset_release");
      predict_valid_i = 1; predict_pc_i = 32'h100;
      #1;
      total++; if (predict_taken_o !== 1'b0 || predict_target_o !== 32'h0)
         $display("FAIL first_lookup got=%0b/%h exp=0/0", predict_taken_o, predict_target_o); else passed++;
      step("first_lookup");
   endtask

   task automatic test_cond_train();
      train(32'h100, 2'd0, 1'b1, 32'h200);
      step("train_cond");
      predict_valid_i = 1; predict_pc_i = 32'h100;
      #1;
      total++; if (predict_taken_o !== 1'b1) $display("FAIL cond_taken got=%0b exp=1", predict_taken_o); else passed++;
      total++; if (predict_target_o !== 32'h200) $display("FAIL cond_target got=%h exp=200", predict_target_o); else passed++;
      step("lookup_cond");
   endtask

   task automatic test_saturation();
      repeat (3) begin train(32'h100, 2'd0, 1'b1, 32'h200); step("train_t"); end
      train(32'h100, 2'd0, 1'b0, 32'h200); step("train_nt");
      predict_valid_i = 1; predict_pc_i = 32'h100;
      #1;
      total++; if (predict_taken_o !== 1'b1 || predict_target_o !== 32'h200)
         $display("FAIL sat_after_one_nt got=%0b/%h exp=1/200", predict_taken_o, predict_target_o); else passed++;
      step("lookup");
      repeat (2) begin train(32'h100, 2'd0, 1'b0, 32'h200); step("train_nt"); end
      predict_valid_i = 1; predict_pc_i = 32'h100;
      #1;
      total++; if (predict_taken_o !== 1'b0 || predict_target_o !== 32'h0)
         $display("FAIL sat_floor got=%0b/%h exp=0/0", predict_taken_o, predict_target_o); else passed++;
      step("lookup");
      // The entry is still present: a used hit shifts history, a miss would not.
      recover_i = 1; recover_ghr_i = 8'h01; recover_ras_snap_i = 7'h0;
      step("recover_ghr1");
      predict_valid_i = 1; predict_pc_i = 32'h100; predict_used_i = 1;
      #1;
      total++; if (predict_ghr_o !== 8'h01) $display("FAIL ghr_recovered got=%h exp=01", predict_ghr_o); else passed++;
      step("use_nt");
      total++; if (predict_ghr_o !== 8'h02) $display("FAIL btb_retained got=%h exp=02", predict_ghr_o); else passed++;
      recover_i = 1; recover_ghr_i = 8'h00; recover_ras_snap_i = 7'h0;
      step("recover_ghr0");
   endtask

   task automatic test_eviction();
      train(32'h1004, 2'd1, 1'b1, 32'hA00); step("alloc1");
      train(32'h2004, 2'd1, 1'b1, 32'hB00); step("alloc2");
      train(32'h3004, 2'd1, 1'b1, 32'hC00); step("alloc3");
      predict_valid_i = 1; predict_pc_i = 32'h1004;
      #1;
      total++; if (predict_taken_o !== 1'b0 || predict_target_o !== 32'h0)
         $display("FAIL evicted got=%0b/%h exp=0/0", predict_taken_o, predict_target_o); else passed++;
      step("lookup1");
      predict_valid_i = 1; predict_pc_i = 32'h2004;
      #1;
      total++; if (predict_taken_o !== 1'b1 || predict_target_o !== 32'hB00)
         $display("FAIL way1_hit got=%0b/%h exp=1/b00", predict_taken_o, predict_target_o); else passed++;
      step("lookup2");
      predict_valid_i = 1; predict_pc_i = 32'h3004;
      #1;
      total++; if (predict_taken_o !== 1'b1 || predict_target_o !== 32'hC00)
         $display("FAIL way0_refill got=%0b/%h exp=1/c00", predict_taken_o, predict_target_o); else passed++;
      step("lookup3");
   endtask

   task automatic test_call_return();
      bit [31:0] exp_ret = RAS_ON ? 32'h404 : 32'h0;
      bit [6:0]  exp_snap = RAS_ON ? 7'h09 : 7'h00;
      train(32'h400, 2'd2, 1'b1, 32'h800); step("train_call");
      train(32'h820, 2'd3, 1'b1, 32'h000); step("train_ret");
      predict_valid_i = 1; predict_pc_i = 32'h400; predict_used_i = 1;
      #1;
      total++; if (predict_taken_o !== 1'b1 || predict_target_o !== 32'h800)
         $display("FAIL call_pred got=%0b/%h exp=1/800", predict_taken_o, predict_target_o); else passed++;
      step("use_call");
      total++; if (predict_ras_snap_o !== exp_snap)
         $display("FAIL call_snap got=%h exp=%h", predict_ras_snap_o, exp_snap); else passed++;
      predict_valid_i = 1; predict_pc_i = 32'h820;
      #1;
      total++; if (predict_taken_o !== 1'b1 || predict_target_o !== exp_ret)
         $display("FAIL ret_pred got=%0b/%h exp=1/%h", predict_taken_o, predict_target_o, exp_ret); else passed++;
      step("lookup_ret");
   endtask

   task automatic test_recover();
      train(32'h5108, 2'd0, 1'b1, 32'h5800); step("train_cond");
      predict_valid_i = 1; predict_pc_i = 32'h5108; predict_used_i = 1;
      #1;
      total++; if (predict_taken_o !== 1'b1 || predict_ghr_o !== 8'h00)
         $display("FAIL rec_pre got=%0b/%h exp=1/00", predict_taken_o, predict_ghr_o); else passed++;
      step("use_cond");
      total++; if (predict_ghr_o !== 8'h01) $display("FAIL ghr_shift got=%h exp=01", predict_ghr_o); else passed++;
      predict_valid_i = 1; predict_pc_i = 32'h5108; predict_used_i = 1;
      recover_i = 1; recover_ghr_i = 8'h05; recover_ras_snap_i = 7'h0;
      step("use_and_recover");
      total++; if (predict_ghr_o !== 8'h05) $display("FAIL rec_ghr got=%h exp=05", predict_ghr_o); else passed++;
      total++; if (predict_ras_snap_o !== 7'h0) $display("FAIL rec_snap got=%h exp=00", predict_ras_snap_o); else passed++;
   endtask

   task automatic test_random();
      bit hit, tk;
      bit [1:0] kind;
      bit [31:0] tg;
      for (int i = 0; i < 400; i++) begin
         predict_valid_i = ($urandom_range(0, 3) != 0);
         predict_pc_i    = rand_pc();
         predict_used_i  = 1'($urandom_range(0, 1));
         train_valid_i   = 1'($urandom_range(0, 1));
         train_pc_i      = rand_pc();
         train_kind_i    = 2'($urandom_range(0, 3));
         train_taken_i   = (train_kind_i == 2'd0) ? 1'($urandom_range(0, 1)) : 1'b1;
         train_target_i  = $urandom & 32'hFFFF_FFFC;
         train_ghr_i     = ($urandom_range(0, 1) != 0) ? m_ghr : 8'($urandom_range(0, 255));
         recover_i       = ($urandom_range(0, 15) == 0);
         recover_ghr_i   = 8'($urandom_range(0, 255));
         recover_ras_snap_i = 7'($urandom_range(0, 7));
         #1;
         model_predict(predict_pc_i, predict_valid_i, hit, kind, tk, tg);
         total++; if (predict_taken_o !== tk) $display("FAIL rnd_taken i=%0d got=%0b exp=%0b", i, predict_taken_o, tk); else passed++;
         total++; if (predict_target_o !== tg) $display("FAIL rnd_target i=%0d got=%h exp=%h", i, predict_target_o, tg); else passed++;
         total++; if (predict_ghr_o !== m_ghr) $display("FAIL rnd_ghr i=%0d got=%h exp=%h", i, predict_ghr_o, m_ghr); else passed++;
         total++; if (predict_ras_snap_o !== model_snap())
            $display("FAIL rnd_snap i=%0d got=%h exp=%h", i, predict_ras_snap_o, model_snap()); else passed++;
         step("random");
      end
   endtask

   task automatic test_async_reset();
      bit [6:0] exp_snap = RAS_ON ? 7'h13 : 7'h00;
      train(32'h2004, 2'd1, 1'b1, 32'hB00);
      recover_i = 1; recover_ghr_i = 8'h5A; recover_ras_snap_i = 7'h13;
      step("train_and_recover");
      predict_valid_i = 1; predict_pc_i = 32'h2004;
      #1;
      total++; if (predict_taken_o !== 1'b1 || predict_target_o !== 32'hB00)
         $display("FAIL pre_reset_hit got=%0b/%h exp=1/b00", predict_taken_o, predict_target_o); else passed++;
      total++; if (predict_ghr_o !== 8'h5A || predict_ras_snap_o !== exp_snap)
         $display("FAIL pre_reset_state got=%h/%h exp=5a/%h", predict_ghr_o, predict_ras_snap_o, exp_snap); else passed++;
      #1 reset_n_i = 0;
      #1;
      total++; if (predict_taken_o !== 1'b0 || predict_target_o !== 32'h0)
         $display("FAIL async_pred got=%0b/%h exp=0/0", predict_taken_o, predict_target_o); else passed++;
      total++; if (predict_ghr_o !== 8'h0 || predict_ras_snap_o !== 7'h0)
         $display("FAIL async_state got=%h/%h exp=0/0", predict_ghr_o, predict_ras_snap_o); else passed++;
      model_reset();
      @(posedge clock_i);
      @(negedge clock_i);
      reset_n_i = 1;
      clear_inputs();
      step("reset_release");
      predict_valid_i = 1; predict_pc_i = 32'h2004;
      #1;
      total++; if (predict_taken_o !== 1'b0 || predict_target_o !== 32'h0)
         $display("FAIL post_reset_2004 got=%0b/%h exp=0/0", predict_taken_o, predict_target_o); else passed++;
      step("lookup");
      predict_valid_i = 1; predict_pc_i = 32'h400;
      #1;
      total++; if (predict_taken_o !== 1'b0 || predict_target_o !== 32'h0)
         $display("FAIL post_reset_400 got=%0b/%h exp=0/0", predict_taken_o, predict_target_o); else passed++;
      step("lookup");
   endtask

   initial begin
      test_reset();
      test_cond_train();
      test_saturation();
      test_eviction();
      test_call_return();
      test_recover();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
